// File: rtl/instruction_fetch_unit.sv
// Fetch front end: owns the PC, issues word reads to instruction memory and
// hands {pc, instruction} to decode through a small FIFO with a valid/ready handshake.
module instruction_fetch_unit #(
   parameter int                    ADDR_WIDTH = 16,
   parameter int                    DATA_WIDTH = 32,
   parameter int                    MEM_WORDS  = 2048,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
   parameter int                    BUF_DEPTH  = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic                  redirect_valid,
   input  logic [ADDR_WIDTH-1:0] redirect_pc,
   output logic                  imem_rd,
   output logic                  imem_wn,
   output logic [ADDR_WIDTH-1:0] imem_address,
   input  logic [DATA_WIDTH-1:0] imem_read_data,
   output logic                  inst_valid,
   input  logic                  inst_ready,
   output logic [DATA_WIDTH-1:0] inst_data,
   output logic [ADDR_WIDTH-1:0] inst_pc
);

   localparam int PTR_W = $clog2(BUF_DEPTH);
   localparam int OCC_W = PTR_W + 1;

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   state_t                r_state;
   logic [ADDR_WIDTH-1:0] r_pc;
   logic                  r_inflight;
   logic [ADDR_WIDTH-1:0] r_inflightPc;
   logic [DATA_WIDTH-1:0] r_bufData [BUF_DEPTH];
   logic [ADDR_WIDTH-1:0] r_bufPc   [BUF_DEPTH];
   logic [PTR_W-1:0]      r_head;
   logic [PTR_W-1:0]      r_tail;
   logic [OCC_W-1:0]      r_occ;

   logic                  w_pop;
   logic                  w_push;
   logic                  w_issue;
   logic [OCC_W:0]        w_pending;
   logic [ADDR_WIDTH-1:0] w_pcNext;

   // A read is only issued when its response is guaranteed a free buffer slot,
   // counting the word already in flight and any word leaving this cycle.
   assign w_pop     = inst_valid & inst_ready;
   assign w_pending = {1'b0, r_occ} + (OCC_W+1)'(r_inflight) - (OCC_W+1)'(w_pop);
   assign w_issue   = (r_state == RUN) & ~redirect_valid
                      & (w_pending < (OCC_W+1)'(BUF_DEPTH));
   assign w_push    = r_inflight & ~redirect_valid;
   assign w_pcNext  = (r_pc == ADDR_WIDTH'(MEM_WORDS - 1)) ? '0 : r_pc + ADDR_WIDTH'(1);

   assign imem_rd      = w_issue;
   assign imem_wn      = 1'b0;
   assign imem_address = r_pc;
   assign inst_valid   = (r_occ != '0);
   assign inst_data    = r_bufData[r_head];
   assign inst_pc      = r_bufPc[r_head];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_pc         <= RESET_PC;
         r_inflight   <= 1'b0;
         r_inflightPc <= '0;
         r_head       <= '0;
         r_tail       <= '0;
         r_occ        <= '0;
         for (int i = 0; i < BUF_DEPTH; i++) begin
            r_bufData[i] <= '0;
            r_bufPc[i]   <= '0;
         end
      end else begin
         case (r_state)
            IDLE:    if (enable)  r_state <= RUN;
            RUN:     if (!enable) r_state <= IDLE;
            default: r_state <= IDLE;
         endcase

         // Redirect drops everything queued or returning; a handshake in the same
         // cycle has already completed on the decode side, so it is simply lost with the flush.
         if (redirect_valid) begin
            r_pc       <= redirect_pc;
            r_inflight <= 1'b0;
            r_head     <= '0;
            r_tail     <= '0;
            r_occ      <= '0;
         end else begin
            if (w_issue) begin
               r_pc         <= w_pcNext;
               r_inflight   <= 1'b1;
               r_inflightPc <= r_pc;
            end else begin
               r_inflight <= 1'b0;
            end
            if (w_push) begin
               r_bufData[r_tail] <= imem_read_data;
               r_bufPc[r_tail]   <= r_inflightPc;
               r_tail            <= r_tail + PTR_W'(1);
            end
            if (w_pop) begin
               r_head <= r_head + PTR_W'(1);
            end
            r_occ <= r_occ + OCC_W'(w_push) - OCC_W'(w_pop);
         end
      end
   end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: a behavioural 1-cycle memory plus a
// PC scoreboard that is compared against every accepted instruction.
module tb_instruction_fetch_unit;

   localparam int ADDR_WIDTH = 16;
   localparam int DATA_WIDTH = 32;
   localparam int MEM_WORDS  = 2048;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic                  enable;
   logic                  redirect_valid;
   logic [ADDR_WIDTH-1:0] redirect_pc;
   logic                  imem_rd;
   logic                  imem_wn;
   logic [ADDR_WIDTH-1:0] imem_address;
   logic [DATA_WIDTH-1:0] imem_read_data = '0;
   logic                  inst_valid;
   logic                  inst_ready;
   logic [DATA_WIDTH-1:0] inst_data;
   logic [ADDR_WIDTH-1:0] inst_pc;

   int total = 0;
   int bad = 0;
   int nDelivered = 0;
   int pcQ[$];
   logic                  prevStall = 1'b0;
   logic [ADDR_WIDTH-1:0] prevPc = '0;

   instruction_fetch_unit #(
      .ADDR_WIDTH(ADDR_WIDTH),
      .DATA_WIDTH(DATA_WIDTH),
      .MEM_WORDS (MEM_WORDS),
      .RESET_PC  (16'h0000),
      .BUF_DEPTH (2)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .enable        (enable),
      .redirect_valid(redirect_valid),
      .redirect_pc   (redirect_pc),
      .imem_rd       (imem_rd),
      .imem_wn       (imem_wn),
      .imem_address  (imem_address),
      .imem_read_data(imem_read_data),
      .inst_valid    (inst_valid),
      .inst_ready    (inst_ready),
      .inst_data     (inst_data),
      .inst_pc       (inst_pc)
   );

   always #5 clk = ~clk;

   // Memory contents are Mem[k] = A000_0000 + k, returned one edge after the read strobe.
   always @(posedge clk) begin
      if (imem_rd) imem_read_data <= 32'hA000_0000 + 32'(imem_address);
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s got=%h exp=%h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic en, input logic rdy, input logic redir,
                                input logic [ADDR_WIDTH-1:0] redirPc);
      enable         = en;
      inst_ready     = rdy;
      redirect_valid = redir;
      redirect_pc    = redirPc;
   endtask

   task automatic pushRange(input int startPc, input int n);
      for (int i = 0; i < n; i++) pcQ.push_back((startPc + i) % MEM_WORDS);
   endtask

   task automatic stepCycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Every handshake is scored at the negedge before the accepting edge.
   always @(negedge clk) begin
      int expPc;
      if (rst_n) begin
         checkOutput("wnLow", 32'(imem_wn), 32'd0);
         if (prevStall) checkOutput("holdPc", 32'(inst_pc), 32'(prevPc));
         if (inst_valid && inst_ready) begin
            nDelivered++;
            if (pcQ.size() == 0) begin
               checkOutput("sbEmpty", 32'(pcQ.size()), 32'd1);
            end else begin
               expPc = pcQ.pop_front();
               checkOutput("instPc", 32'(inst_pc), 32'(expPc));
               checkOutput("instData", inst_data, 32'hA000_0000 + 32'(expPc));
            end
         end
      end
      prevStall = rst_n & inst_valid & ~inst_ready & ~redirect_valid;
      prevPc    = inst_pc;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog got=timeout exp=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int k;
      rst_n = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0, '0);
      #12;
      checkOutput("rstRd",    32'(imem_rd),      32'd0);
      checkOutput("rstWn",    32'(imem_wn),      32'd0);
      checkOutput("rstAddr",  32'(imem_address), 32'h0000);
      checkOutput("rstValid", 32'(inst_valid),   32'd0);
      checkOutput("rstData",  inst_data,         32'd0);
      checkOutput("rstPc",    32'(inst_pc),      32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      stepCycles(1);

      // Stream from reset: issue-to-valid latency and one instruction per cycle.
      pushRange(0, 30);
      applyStimulus(1'b1, 1'b1, 1'b0, '0);
      k = 0;
      while (!imem_rd && k < 10) begin
         stepCycles(1);
         k++;
      end
      checkOutput("issueSeen", 32'(imem_rd), 32'd1);
      stepCycles(1);
      checkOutput("lat1Valid", 32'(inst_valid), 32'd0);
      stepCycles(1);
      checkOutput("lat2Valid", 32'(inst_valid), 32'd1);
      nDelivered = 0;
      stepCycles(8);
      checkOutput("sustain", 32'(nDelivered), 32'd8);

      // Decode stalls: buffer fills, reads stop, then resume without gaps.
      applyStimulus(1'b1, 1'b0, 1'b0, '0);
      stepCycles(6);
      checkOutput("fullNoRd", 32'(imem_rd), 32'd0);
      checkOutput("fullValid", 32'(inst_valid), 32'd1);
      applyStimulus(1'b1, 1'b1, 1'b0, '0);
      nDelivered = 0;
      stepCycles(6);
      checkOutput("resume", 32'(nDelivered), 32'd6);

      // Redirect with a response in flight and decode stalled.
      applyStimulus(1'b1, 1'b0, 1'b1, 16'h0100);
      #1;
      checkOutput("noRdRedir1", 32'(imem_rd), 32'd0);
      stepCycles(1);
      pcQ.delete();
      pushRange(16'h0100, 30);
      applyStimulus(1'b1, 1'b1, 1'b0, '0);
      checkOutput("redirAddr", 32'(imem_address), 32'h0100);
      checkOutput("flushed", 32'(inst_valid), 32'd0);
      stepCycles(8);

      // Redirect with a simultaneous handshake, then wrap at the end of memory.
      applyStimulus(1'b1, 1'b1, 1'b1, 16'd2046);
      #1;
      checkOutput("noRdRedir2", 32'(imem_rd), 32'd0);
      stepCycles(1);
      pcQ.delete();
      pushRange(2046, 30);
      applyStimulus(1'b1, 1'b1, 1'b0, '0);
      checkOutput("wrapAddr", 32'(imem_address), 32'd2046);
      stepCycles(10);

      // Stop fetching mid-stream: the buffered and in-flight words still drain.
      applyStimulus(1'b0, 1'b1, 1'b0, '0);
      nDelivered = 0;
      stepCycles(1);
      for (int i = 0; i < 8; i++) begin
         checkOutput("idleNoRd", 32'(imem_rd), 32'd0);
         stepCycles(1);
      end
      checkOutput("drainCnt", 32'(nDelivered), 32'd3);
      checkOutput("drainEmpty", 32'(inst_valid), 32'd0);

      // Restart, then async reset between edges.
      applyStimulus(1'b1, 1'b1, 1'b0, '0);
      stepCycles(6);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("asyncValid", 32'(inst_valid), 32'd0);
      checkOutput("asyncRd", 32'(imem_rd), 32'd0);
      checkOutput("asyncAddr", 32'(imem_address), 32'h0000);
      pcQ.delete();
      pushRange(0, 30);
      @(negedge clk);
      rst_n = 1'b1;
      nDelivered = 0;
      stepCycles(12);
      checkOutput("restartCnt", 32'(nDelivered), 32'd9);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
